// File: rtl/sync_fifo_lvl.sv
// Synchronous FIFO of any depth with fill level, almost-full/almost-empty flags,
// sticky overflow/underflow errors and a synchronous flush.
module sync_fifo_lvl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned LW       = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_write_data,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_read_data,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_almost_empty,
  output logic [LW-1:0]    o_level,
  output logic             o_overflow,
  output logic             o_underflow
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow, r_underflow;

  logic             w_empty, w_full;
  logic             w_push_acc, w_pop_acc;
  logic             w_ovf_set, w_udf_set;
  logic [PW-1:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;

  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == LW'(DEPTH));

  // Flush discards both requests, so neither moves pointers nor raises an error.
  assign w_push_acc = i_push & (~w_full | i_pop) & ~i_flush;
  assign w_pop_acc  = i_pop & ~w_empty & ~i_flush;
  assign w_ovf_set  = i_push & w_full & ~i_pop & ~i_flush;
  assign w_udf_set  = i_pop & w_empty & ~i_flush;

  assign w_wr_ptr_nxt = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_pop_acc)  r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push_acc && !w_pop_acc) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop_acc && !w_push_acc) begin
        r_level <= r_level - LW'(1);
      end
    end
  end

  // A set event in the same cycle as clr_err keeps the flag high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow & ~i_clr_err) | w_ovf_set;
      r_underflow <= (r_underflow & ~i_clr_err) | w_udf_set;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_write_data;
  end

  assign o_read_data    = r_mem[r_rd_ptr];
  assign o_empty        = w_empty;
  assign o_full         = w_full;
  assign o_almost_full  = (r_level >= LW'(AF_THRESH));
  assign o_almost_empty = (r_level <= LW'(AE_THRESH));
  assign o_level        = r_level;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: directed vector table, hand-written corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_sync_fifo_lvl;
  localparam int unsigned W  = 8;
  localparam int unsigned D  = 10;
  localparam int unsigned AF = 8;
  localparam int unsigned AE = 2;
  localparam int unsigned LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0, push = 1'b0, pop = 1'b0, clr_err = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic          empty, full, afull, aempty, ovf, udf;
  logic [LW-1:0] level;

  int checks = 0;
  int failures = 0;

  sync_fifo_lvl #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_push(push), .i_pop(pop),
    .i_write_data(wdata), .i_clr_err(clr_err), .o_read_data(rdata), .o_empty(empty),
    .o_full(full), .o_almost_full(afull), .o_almost_empty(aempty), .o_level(level),
    .o_overflow(ovf), .o_underflow(udf)
  );

  initial forever #5 clk = ~clk;

  // Reference model: a plain queue plus two error bits.
  logic [W-1:0] q[$];
  bit m_ovf = 0, m_udf = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit p_push, input bit p_pop, input bit p_flush,
                            input bit p_clr, input logic [W-1:0] p_wd);
    int  n;
    bit  so, su, pa, pp;
    n = q.size();
    so = 0;
    su = 0;
    if (p_flush) begin
      q.delete();
    end else begin
      pa = p_push && (n < D || p_pop);
      pp = p_pop && n > 0;
      so = p_push && n == D && !p_pop;
      su = p_pop && n == 0;
      if (pp) void'(q.pop_front());
      if (pa) q.push_back(p_wd);
    end
    m_ovf = (m_ovf && !p_clr) || so;
    m_udf = (m_udf && !p_clr) || su;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".level"}, int'(level), n);
    chk({tag, ".empty"}, int'(empty), int'(n == 0));
    chk({tag, ".full"}, int'(full), int'(n == D));
    chk({tag, ".afull"}, int'(afull), int'(n >= AF));
    chk({tag, ".aempty"}, int'(aempty), int'(n <= AE));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".udf"}, int'(udf), int'(m_udf));
    if (n > 0) chk({tag, ".rdata"}, int'(rdata), int'(q[0]));
  endtask

  // Drive one cycle from just after an edge, then sample 1 time unit after the next edge.
  task automatic cycle(input bit p_push, input bit p_pop, input bit p_flush, input bit p_clr,
                       input logic [W-1:0] p_wd);
    push = p_push; pop = p_pop; flush = p_flush; clr_err = p_clr; wdata = p_wd;
    @(posedge clk);
    #1;
    push = 0; pop = 0; flush = 0; clr_err = 0;
    model_step(p_push, p_pop, p_flush, p_clr, p_wd);
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    check_model("reset");
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  typedef struct {
    bit           push, pop, flush, clr;
    logic [W-1:0] wd;
    int           lvl;
    bit           ovf, udf;
    bit           rd_chk;
    logic [W-1:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit pu, bit po, bit cl, logic [W-1:0] wd, int lvl, bit eo,
                              bit eu, bit rc, logic [W-1:0] rd);
    vec_t v;
    v.push = pu; v.pop = po; v.flush = 0; v.clr = cl; v.wd = wd;
    v.lvl = lvl; v.ovf = eo; v.udf = eu; v.rd_chk = rc; v.rd = rd;
    vecs.push_back(v);
  endfunction

  initial begin
    // Directed table starting from reset.
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);            // pop on empty
    add(1, 1, 0, 8'h33, 1, 0, 1, 1, 8'h33);            // push+pop on empty: push only
    add(0, 0, 1, 8'h00, 1, 0, 0, 1, 8'h33);            // clr_err
    for (int i = 2; i <= 10; i++) add(1, 0, 0, 8'(i), i, 0, 0, 1, 8'h33);
    add(1, 0, 0, 8'hAA, 10, 1, 0, 1, 8'h33);           // overflow when full
    add(0, 0, 1, 8'h00, 10, 0, 0, 1, 8'h33);
    add(1, 1, 0, 8'h55, 10, 0, 0, 1, 8'h02);           // full push+pop
    for (int k = 1; k <= 8; k++) add(0, 1, 0, 8'h00, 10 - k, 0, 0, 1, 8'(k + 2));
    add(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h55);
    add(0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);

    #2;
    do_reset();
    foreach (vecs[i]) begin
      push = vecs[i].push; pop = vecs[i].pop; flush = vecs[i].flush;
      clr_err = vecs[i].clr; wdata = vecs[i].wd;
      @(posedge clk);
      #1;
      push = 0; pop = 0; flush = 0; clr_err = 0;
      chk($sformatf("vec%0d.level", i), int'(level), vecs[i].lvl);
      chk($sformatf("vec%0d.afull", i), int'(afull), int'(vecs[i].lvl >= AF));
      chk($sformatf("vec%0d.aempty", i), int'(aempty), int'(vecs[i].lvl <= AE));
      chk($sformatf("vec%0d.full", i), int'(full), int'(vecs[i].lvl == D));
      chk($sformatf("vec%0d.empty", i), int'(empty), int'(vecs[i].lvl == 0));
      chk($sformatf("vec%0d.ovf", i), int'(ovf), int'(vecs[i].ovf));
      chk($sformatf("vec%0d.udf", i), int'(udf), int'(vecs[i].udf));
      if (vecs[i].rd_chk) chk($sformatf("vec%0d.rdata", i), int'(rdata), int'(vecs[i].rd));
    end

    // Fill, drain, then wrap past the last index.
    do_reset();
    for (int i = 1; i <= 10; i++) begin cycle(1, 0, 0, 0, 8'(i)); check_model("fill"); end
    for (int i = 1; i <= 10; i++) begin
      chk("drain.order", int'(rdata), i);
      cycle(0, 1, 0, 0, 8'h00);
      check_model("drain");
    end
    for (int i = 11; i <= 15; i++) begin cycle(1, 0, 0, 0, 8'(i)); check_model("wrapfill"); end
    for (int i = 11; i <= 15; i++) begin
      chk("wrap.order", int'(rdata), i);
      cycle(0, 1, 0, 0, 8'h00);
      check_model("wrapdrain");
    end

    // Flush at level 5 with a push in the same cycle.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 8'(8'h40 + i));
    check_model("preflush");
    cycle(1, 0, 1, 0, 8'h77);
    check_model("flush");
    chk("flush.level", int'(level), 0);
    chk("flush.ovf", int'(ovf), 0);

    // Asynchronous reset between edges at level 7.
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 8'(8'h60 + i));
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 0, 0, 0, 8'h70);
    cycle(1, 0, 0, 0, 8'h71);
    check_model("prerst");
    #2;
    rst = 1;
    #1;
    chk("arst.level", int'(level), 0);
    chk("arst.empty", int'(empty), 1);
    chk("arst.aempty", int'(aempty), 1);
    chk("arst.full", int'(full), 0);
    q.delete();
    m_ovf = 0;
    m_udf = 0;
    #2;
    rst = 0;
    @(posedge clk);
    #1;
    check_model("postrst");

    // Randomized traffic with phases biased toward filling or draining.
    for (int i = 0; i < 3000; i++) begin
      int  bias;
      bit  rp, ro, rf, rc;
      bias = (i / 200) % 3;
      rp = ($urandom_range(99) < (bias == 0 ? 80 : (bias == 1 ? 20 : 50)));
      ro = ($urandom_range(99) < (bias == 0 ? 20 : (bias == 1 ? 80 : 50)));
      rf = ($urandom_range(99) < 2);
      rc = ($urandom_range(99) < 5);
      cycle(rp, ro, rf, rc, 8'($urandom));
      check_model("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sync_fifo_lvl.md
# sync_fifo_lvl

Parametrised synchronous FIFO for the UART TX and RX data paths. It replaces the fixed-depth FIFO with one where any depth is legal (no power-of-two requirement), pointers wrap correctly at DEPTH-1, and the fill level is visible. It adds programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between the host write/read logic and the UART shift-register state machines.

## Interface
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of storage entries (>=2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when level >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH (0..DEPTH-1)
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of FIFO contents
- push  input  1  write request
- pop  input  1  read request (head word consumed)
- write_data  input  WIDTH  word written on accepted push
- read_data  output  WIDTH  current head word, combinational from storage
- empty  output  1  level == 0
- full  output  1  level == DEPTH
- almost_full  output  1  level >= AF_THRESH
- almost_empty  output  1  level <= AE_THRESH
- level  output  $clog2(DEPTH+1)  number of stored words
- overflow  output  1  sticky: push rejected because full
- underflow  output  1  sticky: pop rejected because empty
- clr_err  input  1  synchronous clear of overflow/underflow

## Operation
- Pointers wr_ptr, rd_ptr are $clog2(DEPTH) bits wide; increment wraps DEPTH-1 -> 0. Never compare against an all-ones constant.
- Accepted push: push && (!full || pop). Writes write_data to mem[wr_ptr] and advances wr_ptr.
- Accepted pop: pop && !empty. Advances rd_ptr.
- Full with push && pop: both are accepted. The head word is read before the overwrite lands, and level stays at DEPTH.
- Empty with push && pop: the push is accepted and the pop is rejected (no bypass). level becomes 1 and underflow is set.
- Level update:
  - +1 on a lone accepted push
  - -1 on a lone accepted pop
  - unchanged when both or neither are accepted
- Status outputs: empty, full, almost_full and almost_empty are decoded combinationally from level.
- overflow is set on push && full && !pop. underflow is set on pop && empty. Both hold until clr_err.
- A set event in the same cycle as clr_err wins, so the flag stays 1.
- flush: pointers and level go to 0 at the next edge. It overrides push and pop in that cycle.
  - Storage is not cleared.
  - Error flags are unaffected.
  - A push during flush is discarded without setting overflow.
- Storage has no reset. read_data is undefined while empty.

## Timing
- Reset (async assert, sync to clk on release is not required inside the block): wr_ptr=rd_ptr=0, level=0, overflow=underflow=0. Therefore empty=1, full=0, almost_empty=1, almost_full=0 immediately on assertion.
- Reset asserted mid-operation discards all contents at once. There is no partial push or pop.
- Push latency: word pushed at edge N appears on read_data, with empty=0 and level updated, right after edge N.
- Pop: read_data shows the head before the edge. The next word appears right after the popping edge.
- Flags follow level in the same cycle; there is no extra registering.

## Test plan
- DEPTH=10: push 1..10 -> level=10, full=1 after 10th edge. Pop 10 times -> reads 1..10 in order, empty=1. Then push 11..15 and pop -> 11..15, which checks wrap past index 9.
- Full FIFO, push=1 pop=0 with data 0xAA -> level stays 10, overflow=1, contents unchanged. clr_err pulse -> overflow=0.
- Full FIFO, push=1 pop=1 with data 0x55 -> old head read, level stays 10. 0x55 is read last after draining.
- Empty FIFO, pop=1 -> underflow=1, level=0. Same cycle push 0x33 with pop -> level=1, read_data=0x33.
- AF_THRESH=8, AE_THRESH=2: step level 0..10. almost_empty=1 for 0..2, almost_full=1 for 8..10.
- Level 5, flush=1 with push=1 -> level=0, empty=1, overflow=0. Assert rst asynchronously at level 7 between edges -> empty=1, level=0 before the next edge.
